// File: rtl/cmd_handler.sv
// Serial command handler: decodes UART command words, runs sensor reads, returns responses.
// Accepted edge reaches sensor_req or tx_start within 2 cycles; HOLD waits on data_transmitted.
module cmd_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_ADDR       = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_recived,
  output logic [15:0] data_out,
  output logic        tx_start,
  input  logic        data_transmitted,
  output logic        sensor_req,
  output logic [4:0]  sensor_addr,
  input  logic        sensor_ack,
  input  logic [15:0] sensor_data,
  input  logic        sensor_err,
  output logic        cont_mode,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4,
    HOLD   = 3'd5
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             rcv_q;
  logic [15:0]      cmd_q, cmd_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       cont_addr_q, cont_addr_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      data_out_q, data_out_d;
  logic [4:0]       sensor_addr_q, sensor_addr_d;
  logic             rise;

  assign rise = data_recived & ~rcv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rcv_q         <= 1'b0;
      cmd_q         <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      cont_addr_q   <= '0;
      cont_q        <= 1'b0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      sensor_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      rcv_q         <= data_recived;
      cmd_q         <= cmd_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      cont_addr_q   <= cont_addr_d;
      cont_q        <= cont_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      sensor_addr_q <= sensor_addr_d;
    end
  end

  // data_out_d only changes on transitions into SEND, so the word is frozen through HOLD.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    op_d          = op_q;
    addr_d        = addr_q;
    cont_addr_d   = cont_addr_q;
    cont_d        = cont_q;
    cnt_d         = cnt_q;
    data_out_d    = data_out_q;
    sensor_addr_d = sensor_addr_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          cmd_d   = data_in;
          state_d = DECODE;
        end
      end

      DECODE: begin
        addr_d = cmd_q[7:0];
        op_d   = cmd_q[15:8];
        if (32'(cmd_q[7:0]) > MAX_ADDR) begin
          data_out_d = {8'hFE, cmd_q[7:0]};
          state_d    = SEND;
        end else begin
          case (cmd_q[15:8])
            8'h01, 8'h02, 8'h03: begin
              sensor_addr_d = cmd_q[4:0];
              state_d       = REQ;
            end
            8'h04: begin
              cont_d      = 1'b1;
              cont_addr_d = cmd_q[7:0];
              data_out_d  = 16'h0A00;
              state_d     = SEND;
            end
            8'h05: begin
              cont_d     = 1'b0;
              data_out_d = 16'h0B00;
              state_d    = SEND;
            end
            default: begin
              data_out_d = {8'hFF, cmd_q[15:8]};
              state_d    = SEND;
            end
          endcase
        end
      end

      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (sensor_ack) begin
          state_d = SEND;
          if (sensor_err) begin
            data_out_d = {8'h1F, addr_q};
          end else begin
            case (op_q)
              8'h01:   data_out_d = {8'h09, sensor_data[7:0]};
              8'h02:   data_out_d = {8'h08, sensor_data[15:8]};
              default: data_out_d = 16'h0700;
            endcase
          end
        end else if (cnt_q == CNT_LAST) begin
          data_out_d = {8'h1F, addr_q};
          state_d    = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SEND: state_d = HOLD;

      HOLD: begin
        // A new command in continuous mode pre-empts the next implicit read.
        if (cont_q && rise) begin
          cmd_d   = data_in;
          state_d = DECODE;
        end else if (data_transmitted) begin
          if (cont_q) begin
            op_d          = 8'h01;
            addr_d        = cont_addr_q;
            sensor_addr_d = cont_addr_q[4:0];
            state_d       = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out    = data_out_q;
  assign tx_start    = (state_q == SEND);
  assign sensor_req  = (state_q == REQ);
  assign sensor_addr = sensor_addr_q;
  assign cont_mode   = cont_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_cmd_handler.sv
// Randomized bench for cmd_handler against a transaction-level response model.
module tb_cmd_handler;
  localparam int T   = 24;
  localparam int MAX = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_recived;
  logic [15:0] data_out;
  logic        tx_start;
  logic        data_transmitted;
  logic        sensor_req;
  logic [4:0]  sensor_addr;
  logic        sensor_ack;
  logic [15:0] sensor_data;
  logic        sensor_err;
  logic        cont_mode;
  logic [2:0]  state_out;

  cmd_handler #(.TIMEOUT_CYCLES(T), .MAX_ADDR(MAX)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_recived(data_recived),
    .data_out(data_out), .tx_start(tx_start), .data_transmitted(data_transmitted),
    .sensor_req(sensor_req), .sensor_addr(sensor_addr), .sensor_ack(sensor_ack),
    .sensor_data(sensor_data), .sensor_err(sensor_err), .cont_mode(cont_mode),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int req_cnt = 0;
  int exp_tx = 0;
  int exp_req = 0;
  bit model_cont = 0;

  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (sensor_req) req_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_needs_sensor(input logic [7:0] code, input logic [7:0] addr);
    return (addr <= MAX) && (code == 8'h01 || code == 8'h02 || code == 8'h03);
  endfunction

  function automatic logic [15:0] model_resp(input logic [7:0] code, input logic [7:0] addr,
                                             input bit acked, input bit err, input logic [15:0] sd);
    if (addr > MAX) return {8'hFE, addr};
    case (code)
      8'h01, 8'h02, 8'h03: begin
        if (!acked || err) return {8'h1F, addr};
        if (code == 8'h01) return {8'h09, sd[7:0]};
        if (code == 8'h02) return {8'h08, sd[15:8]};
        return 16'h0700;
      end
      8'h04:   return 16'h0A00;
      8'h05:   return 16'h0B00;
      default: return {8'hFF, code};
    endcase
  endfunction

  task automatic send_cmd(input logic [15:0] w, input int hold);
    int guard = 0;
    while (data_recived && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    data_in = w;
    data_recived = 1'b1;
    fork
      begin
        automatic int h = hold;
        repeat (h) @(negedge clk);
        data_recived = 1'b0;
      end
    join_none
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (sensor_req || tx_start) begin lat = i; break; end
    end
  endtask

  task automatic wait_tx(input int budget, output int n);
    n = -1;
    for (int i = 0; i <= budget; i++) begin
      if (tx_start) begin n = i; break; end
      @(negedge clk);
    end
  endtask

  // Entered on the cycle sensor_req is high; returns on the tx_start cycle.
  task automatic serve(input logic [7:0] addr, input int delay, input bit err,
                       input logic [15:0] sd, input bit inject);
    int n;
    int left;
    check("sensor_addr", sensor_addr, addr[4:0]);
    exp_req++;
    left = delay;
    if (inject && delay >= 2 && !data_recived) begin
      data_in = 16'h0107;
      data_recived = 1'b1;
      @(negedge clk);
      data_recived = 1'b0;
      left = delay - 1;
    end
    if (delay <= T) begin
      repeat (left) @(negedge clk);
      sensor_ack = 1'b1; sensor_err = err; sensor_data = sd;
      @(negedge clk);
      sensor_ack = 1'b0; sensor_err = 1'b0;
      wait_tx(4, n);
      check("ack_to_tx", n, 0);
    end else begin
      wait_tx(T + 4 - (delay - left), n);
      check("timeout_cycles", n + (delay - left), T + 1);
    end
  endtask

  task automatic finish_hold(input logic [15:0] exp, input bit inject, input int hc);
    for (int k = 0; k < hc; k++) begin
      @(negedge clk);
      check("hold_data", data_out, exp);
    end
    if (inject && !model_cont && !data_recived) begin
      data_in = 16'h0201;
      data_recived = 1'b1;
      @(negedge clk);
      data_recived = 1'b0;
    end
    data_transmitted = 1'b1;
    @(negedge clk);
    data_transmitted = 1'b0;
  endtask

  task automatic txn(input logic [15:0] cmd, input int hold, input int delay, input bit err,
                     input logic [15:0] sd, input bit inject);
    logic [15:0] exp;
    bit needs;
    int lat;
    needs = model_needs_sensor(cmd[15:8], cmd[7:0]);
    exp = model_resp(cmd[15:8], cmd[7:0], delay <= T, err, sd);
    send_cmd(cmd, hold);
    wait_start(lat);
    check("start_latency", (lat >= 1 && lat <= 2), 1);
    if (lat == 0) return;
    check("req_vs_tx", sensor_req, needs);
    if (sensor_req) serve(cmd[7:0], delay, err, sd, inject);
    check("resp", data_out, exp);
    exp_tx++;
    finish_hold(exp, inject, $urandom_range(1, 3));
    check("back_idle", state_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] code, addr;
    logic [15:0] sd;
    int pick, delay, lat, tx0;

    reset = 1'b1; data_in = '0; data_recived = 1'b0; data_transmitted = 1'b0;
    sensor_ack = 1'b0; sensor_data = '0; sensor_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_sensor_req", sensor_req, 0);
    check("rst_sensor_addr", sensor_addr, 0);
    check("rst_cont_mode", cont_mode, 0);
    check("rst_state", state_out, 0);
    reset = 1'b0;
    @(negedge clk);

    txn(16'h0105, 1, 3, 0, 16'h3A19, 0);
    txn(16'h0220, 1, 1, 0, 16'h0000, 0);
    txn(16'h0103, 1, T + 3, 0, 16'h0000, 0);
    txn(16'h7700, 10, 1, 0, 16'h0000, 0);
    txn(16'h0204, 1, T, 0, 16'h5566, 0);
    txn(16'h0301, 2, 2, 1, 16'hFFFF, 0);
    txn(16'h0302, 1, 4, 0, 16'hABCD, 1);
    txn(16'h011F, 1, 2, 0, 16'h00C3, 1);
    txn(16'h051F, 1, 1, 0, 16'h0000, 1);
    txn(16'h0520, 1, 1, 0, 16'h0000, 0);

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 3) code = 8'h01;
      else if (pick < 5) code = 8'h02;
      else if (pick < 7) code = 8'h03;
      else code = 8'($urandom_range(0, 255));
      if (code == 8'h04) code = 8'h84;
      addr = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      delay = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(1, 8);
      txn({code, addr}, $urandom_range(1, 10), delay, $urandom_range(0, 4) == 0,
          16'($urandom), $urandom_range(0, 3) == 0);
    end

    // Continuous mode: enable, a few implicit reads, then disable from HOLD.
    send_cmd(16'h0402, 2);
    wait_start(lat);
    check("cont_start_latency", (lat >= 1 && lat <= 2), 1);
    check("cont_on_resp", data_out, 16'h0A00);
    exp_tx++;
    model_cont = 1;
    @(negedge clk);
    check("cont_mode_on", cont_mode, 1);
    for (int r = 0; r < 3; r++) begin
      data_transmitted = 1'b1;
      @(negedge clk);
      data_transmitted = 1'b0;
      check("cont_implicit_req", sensor_req, 1);
      sd = 16'($urandom);
      serve(8'h02, $urandom_range(1, 5), 0, sd, 0);
      check("cont_resp", data_out, {8'h09, sd[7:0]});
      exp_tx++;
      @(negedge clk);
    end
    send_cmd(16'h0500, 1);
    wait_start(lat);
    check("cont_off_latency", (lat >= 1 && lat <= 2), 1);
    check("cont_off_is_tx", tx_start, 1);
    check("cont_off_resp", data_out, 16'h0B00);
    exp_tx++;
    model_cont = 0;
    @(negedge clk);
    check("cont_mode_off", cont_mode, 0);
    data_transmitted = 1'b1;
    @(negedge clk);
    data_transmitted = 1'b0;
    check("cont_back_idle", state_out, 0);

    // Reset while waiting on the sensor, with continuous mode active.
    send_cmd(16'h0407, 1);
    wait_start(lat);
    check("rstw_on_resp", data_out, 16'h0A00);
    exp_tx++;
    @(negedge clk);
    data_transmitted = 1'b1;
    @(negedge clk);
    data_transmitted = 1'b0;
    check("rstw_req", sensor_req, 1);
    check("rstw_addr", sensor_addr, 7);
    exp_req++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_data_out", data_out, 0);
    check("rstw_tx_start", tx_start, 0);
    check("rstw_sensor_req", sensor_req, 0);
    check("rstw_sensor_addr", sensor_addr, 0);
    check("rstw_cont_mode", cont_mode, 0);
    check("rstw_state", state_out, 0);
    reset = 1'b0;
    tx0 = tx_cnt;
    @(negedge clk);
    sensor_ack = 1'b1; sensor_data = 16'h1234;
    @(negedge clk);
    sensor_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("rstw_late_ack_tx", tx_cnt, tx0);
    check("rstw_late_ack_state", state_out, 0);
    check("rstw_late_ack_data", data_out, 0);

    check("tx_pulse_count", tx_cnt, exp_tx);
    check("req_pulse_count", req_cnt, exp_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_handler.md
CMD_HANDLER -- requirements
Module: cmd_handler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, the maximum number of clock cycles to wait for sensor_ack.
REQ-002 SHALL have parameter MAX_ADDR, default 31, the highest valid sensor address.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_in, input, 16 bits: received command word from the UART receiver; [15:8] is the command code, [7:0] is the sensor address.
REQ-006 SHALL have port data_recived, input, 1 bit: receiver word-complete flag, which may be held high for several cycles.
REQ-007 SHALL have port data_out, output, 16 bits: response word for the UART transmitter; [15:8] is the response code, [7:0] is the value.
REQ-008 SHALL have port tx_start, output, 1 bit: one-cycle pulse requesting transmission of data_out.
REQ-009 SHALL have port data_transmitted, input, 1 bit: transmitter done flag.
REQ-010 SHALL have port sensor_req, output, 1 bit: one-cycle sensor read request.
REQ-011 SHALL have port sensor_addr, output, 5 bits: address of the sensor being read.
REQ-012 SHALL have port sensor_ack, input, 1 bit: sensor result valid, one cycle.
REQ-013 SHALL have port sensor_data, input, 16 bits: sensor result; [15:8] is humidity, [7:0] is temperature.
REQ-014 SHALL have port sensor_err, input, 1 bit: sensor fault, qualified by sensor_ack.
REQ-015 SHALL have port cont_mode, output, 1 bit: continuous-temperature mode active.
REQ-016 SHALL have port state_out, output, 3 bits: current FSM state encoding.

Function
REQ-017 SHALL implement FSM states IDLE=0, DECODE=1, REQ=2, WAIT=3, SEND=4, HOLD=5.
REQ-018 SHALL accept a command only on the rising edge of data_recived (high now, low the previous cycle) while in IDLE, capturing data_in in the same cycle.
REQ-019 SHALL ignore data_recived edges in all states other than IDLE; such commands are dropped with no response.
REQ-020 SHALL, in DECODE, reject an address greater than MAX_ADDR with response {0xFE, addr} and go to SEND, regardless of command code.
REQ-021 SHALL decode command 0x01 (read temperature) and 0x02 (read humidity) as a transition to REQ.
REQ-022 SHALL decode command 0x03 (status) as a transition to REQ, with the sensor result used only for OK/fault.
REQ-023 SHALL decode command 0x04 by setting cont_mode, latching the address, and responding {0x0A, 0x00}.
REQ-024 SHALL decode command 0x05 by clearing cont_mode and responding {0x0B, 0x00}.
REQ-025 SHALL respond {0xFF, code} to any other command code.
REQ-026 SHALL pulse sensor_req in REQ for exactly one cycle with sensor_addr = addr[4:0], then enter WAIT with the timeout counter cleared.
REQ-027 SHALL, in WAIT, on sensor_ack with sensor_err=0, build the response as follows: 0x01 -> {0x09, sensor_data[7:0]}; 0x02 -> {0x08, sensor_data[15:8]}; 0x03 -> {0x07, 0x00}.
REQ-028 SHALL, in WAIT, respond {0x1F, addr} on sensor_ack with sensor_err=1.
REQ-029 SHALL, in WAIT, respond {0x1F, addr} when the counter reaches TIMEOUT_CYCLES-1 without sensor_ack, with ack taking priority if both occur in the same cycle.
REQ-030 SHALL update data_out only on entry to SEND and hold it stable through HOLD.
REQ-031 SHALL pulse tx_start for exactly one cycle in SEND and then enter HOLD.
REQ-032 SHALL leave HOLD on the first cycle data_transmitted is high.
REQ-033 SHALL, on leaving HOLD, go to IDLE if cont_mode=0.
REQ-034 SHALL, on leaving HOLD, go to REQ if cont_mode=1, issuing an implicit 0x01 read on the latched address.
REQ-035 SHALL, in continuous mode, keep IDLE-style rising-edge acceptance on the data_recived edge in HOLD, so that command 0x05 can end continuous mode; this edge pre-empts the implicit read and goes to DECODE.
REQ-036 SHALL latency-bound a command: at most 2 cycles from the accepted edge to sensor_req or tx_start, excluding sensor wait.

Reset
REQ-037 SHALL, on reset high at any clock edge, enter IDLE, including mid-transaction, with any in-flight response discarded and no tx_start issued.
REQ-038 SHALL, on reset, drive data_out=0x0000, tx_start=0, sensor_req=0, sensor_addr=0, cont_mode=0, state_out=0.
REQ-039 SHALL clear the timeout counter and the data_recived edge register on reset.

Verification
REQ-040 SHALL verify: data_in=0x0105 edge, then sensor_ack with sensor_data=0x3A19, err=0 -> sensor_addr=5, data_out=0x0919, one tx_start.
REQ-041 SHALL verify: data_in=0x0220 (addr 32) -> data_out=0xFE20, no sensor_req.
REQ-042 SHALL verify: data_in=0x0103 with no sensor_ack for TIMEOUT_CYCLES cycles -> data_out=0x1F03.
REQ-043 SHALL verify: data_in=0x0402, then repeated data_transmitted -> successive sensor_req to addr 2 with 0x09xx responses; then data_in=0x0500 -> 0x0B00, cont_mode=0, return to IDLE.
REQ-044 SHALL verify: data_in=0x7700 -> 0xFF77; data_recived held high 10 cycles -> exactly one response.
REQ-045 SHALL verify: reset asserted in WAIT -> all outputs at reset values next cycle, and a later sensor_ack is ignored.
